// File: rtl/seg7_anim_pkg.sv
// Shared defaults and types for the seven-segment animation engine.
package seg7_anim_pkg;

   localparam int unsigned NUM_DIGITS_DEF  = 4;
   localparam int unsigned CNT_W_DEF       = 25;
   localparam int unsigned FRAME_W_DEF     = 6;
   localparam int unsigned ANIM_W_DEF      = 6;
   localparam int unsigned ANIM_MAX_DEF    = 50;
   localparam int unsigned PERIOD_RST_DEF  = 10_000_000;
   localparam int unsigned PERIOD_STEP_DEF = 1_000_000;
   localparam int unsigned PERIOD_MIN_DEF  = 1_000_000;
   localparam int unsigned PERIOD_MAX_DEF  = 19_000_000;
   localparam int unsigned SCAN_DIV_DEF    = 10_000;

   // Resolved speed request for the current cycle
   typedef enum logic [1:0] {
      SPD_HOLD,
      SPD_DOWN,
      SPD_UP
   } speed_cmd_e;

endpackage

// File: rtl/seg7_anim_engine_if.sv
// Control pulses in, animation/frame/scan state out.
interface seg7_anim_engine_if
   import seg7_anim_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF,
   parameter int unsigned FRAME_W    = FRAME_W_DEF,
   parameter int unsigned ANIM_W     = ANIM_W_DEF
);

   logic                  anim_inc;
   logic                  anim_dec;
   logic                  speed_down;
   logic                  speed_up;
   logic                  pause_tgl;
   logic                  dir_tgl;
   logic [FRAME_W-1:0]    frame_limit;
   logic [ANIM_W-1:0]     anim;
   logic [FRAME_W-1:0]    frame;
   logic [NUM_DIGITS-1:0] digit_sel;
   logic                  tick;
   logic                  paused;
   logic                  dir_rev;
   logic [CNT_W-1:0]      period;

   modport master (
      output anim_inc, anim_dec, speed_down, speed_up, pause_tgl, dir_tgl, frame_limit,
      input  anim, frame, digit_sel, tick, paused, dir_rev, period
   );

   modport slave (
      input  anim_inc, anim_dec, speed_down, speed_up, pause_tgl, dir_tgl, frame_limit,
      output anim, frame, digit_sel, tick, paused, dir_rev, period
   );

endinterface

// File: rtl/seg7_tick_gen.sv
// Programmable-period divider: counts 0..period-1 and strobes tick on wrap.
// next_period lets the owner shrink the period without overshooting it.
module seg7_tick_gen #(
   parameter int unsigned W = 25
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ena,
   input  logic         clr,
   input  logic [W-1:0] period,
   input  logic [W-1:0] next_period,
   output logic         tick
);

   logic [W-1:0] cnt;
   logic         at_end;
   logic         shrink;
   logic         clr_all;

   // Terminal count, and a silent restart when a shorter period would be overrun
   always_comb begin
      at_end  = (cnt >= period - W'(1));
      shrink  = (next_period < period) && (cnt >= next_period - W'(1));
      clr_all = clr | shrink;
      tick    = ena & ~clr_all & at_end;
   end

   // Divider count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (ena) begin
         if (clr_all || at_end) cnt <= '0;
         else                   cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/seg7_anim_engine.sv
// Animation index, frame stepping, speed/pause/direction control and digit scan
// for a bank of multiplexed seven-segment digits.
module seg7_anim_engine
   import seg7_anim_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = NUM_DIGITS_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned FRAME_W     = FRAME_W_DEF,
   parameter int unsigned ANIM_W      = ANIM_W_DEF,
   parameter int unsigned ANIM_MAX    = ANIM_MAX_DEF,
   parameter int unsigned PERIOD_RST  = PERIOD_RST_DEF,
   parameter int unsigned PERIOD_STEP = PERIOD_STEP_DEF,
   parameter int unsigned PERIOD_MIN  = PERIOD_MIN_DEF,
   parameter int unsigned PERIOD_MAX  = PERIOD_MAX_DEF,
   parameter int unsigned SCAN_DIV    = SCAN_DIV_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   seg7_anim_engine_if.slave  bus
);

   localparam int unsigned       SCAN_W = $clog2(SCAN_DIV + 1);
   localparam logic [SCAN_W-1:0] SCAN_P = SCAN_W'(SCAN_DIV);
   localparam logic [CNT_W:0]    P_STEP = (CNT_W+1)'(PERIOD_STEP);
   localparam logic [CNT_W:0]    P_MIN  = (CNT_W+1)'(PERIOD_MIN);
   localparam logic [CNT_W:0]    P_MAX  = (CNT_W+1)'(PERIOD_MAX);
   localparam logic [ANIM_W-1:0] A_MAX  = ANIM_W'(ANIM_MAX);

   logic [ANIM_W-1:0]     anim_q;
   logic [FRAME_W-1:0]    frame_q;
   logic [NUM_DIGITS-1:0] digit_q;
   logic [CNT_W-1:0]      period_q;
   logic                  tick_q;
   logic                  paused_q;
   logic                  dir_q;

   speed_cmd_e            spd;
   logic [CNT_W-1:0]      period_nxt;
   logic                  anim_chg;
   logic                  paused_nxt;
   logic                  div_wrap;
   logic                  scan_wrap;
   logic                  adv;

   // Resolve this cycle's speed request, pause state and frame advance
   always_comb begin
      spd = SPD_HOLD;
      if (bus.speed_down) begin
         if ({1'b0, period_q} + P_STEP <= P_MAX) spd = SPD_DOWN;
      end else if (bus.speed_up) begin
         if ({1'b0, period_q} >= P_MIN + P_STEP) spd = SPD_UP;
      end
      period_nxt = period_q;
      case (spd)
         SPD_DOWN: period_nxt = period_q + CNT_W'(PERIOD_STEP);
         SPD_UP:   period_nxt = period_q - CNT_W'(PERIOD_STEP);
         default:  period_nxt = period_q;
      endcase
      anim_chg   = bus.anim_inc | bus.anim_dec;
      paused_nxt = paused_q ^ bus.pause_tgl;
      adv        = div_wrap & ~paused_nxt;
   end

   seg7_tick_gen #(.W(CNT_W)) u_frame_div (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .clr         (anim_chg),
      .period      (period_q),
      .next_period (period_nxt),
      .tick        (div_wrap)
   );

   seg7_tick_gen #(.W(SCAN_W)) u_scan_div (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .clr         (1'b0),
      .period      (SCAN_P),
      .next_period (SCAN_P),
      .tick        (scan_wrap)
   );

   // Registered animation, frame, mode and scan state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         anim_q   <= '0;
         frame_q  <= '0;
         tick_q   <= 1'b0;
         paused_q <= 1'b0;
         dir_q    <= 1'b0;
         period_q <= CNT_W'(PERIOD_RST);
         digit_q  <= NUM_DIGITS'(1);
      end else if (ena) begin
         tick_q   <= adv;
         paused_q <= paused_nxt;
         dir_q    <= dir_q ^ bus.dir_tgl;
         period_q <= period_nxt;

         if (bus.anim_inc)      anim_q <= (anim_q == A_MAX) ? '0 : anim_q + ANIM_W'(1);
         else if (bus.anim_dec) anim_q <= (anim_q == '0) ? A_MAX : anim_q - ANIM_W'(1);

         // Out-of-range frame (limit shrank) restarts ahead of any tick
         if (anim_chg || (frame_q > bus.frame_limit)) begin
            frame_q <= '0;
         end else if (adv) begin
            if (!dir_q) frame_q <= (frame_q == bus.frame_limit) ? '0 : frame_q + FRAME_W'(1);
            else        frame_q <= (frame_q == '0) ? bus.frame_limit : frame_q - FRAME_W'(1);
         end

         // Shift/or form keeps the rotate legal for a single digit
         if (scan_wrap) digit_q <= (digit_q << 1) | (digit_q >> (NUM_DIGITS - 1));
      end
   end

   assign bus.anim      = anim_q;
   assign bus.frame     = frame_q;
   assign bus.digit_sel = digit_q;
   assign bus.tick      = tick_q;
   assign bus.paused    = paused_q;
   assign bus.dir_rev   = dir_q;
   assign bus.period    = period_q;

endmodule

// File: tb/tb_seg7_anim_engine.sv
// Directed bench for seg7_anim_engine with shortened periods.
module tb_seg7_anim_engine;

   logic clk = 1'b0;
   logic rst_n;
   logic ena;
   int   checks = 0;
   int   errors = 0;
   int   ncyc   = 0;

   seg7_anim_engine_if #(.NUM_DIGITS(4), .CNT_W(25), .FRAME_W(6), .ANIM_W(6)) bus ();

   seg7_anim_engine #(
      .NUM_DIGITS  (4),
      .CNT_W       (25),
      .FRAME_W     (6),
      .ANIM_W      (6),
      .ANIM_MAX    (50),
      .PERIOD_RST  (10),
      .PERIOD_STEP (2),
      .PERIOD_MIN  (2),
      .PERIOD_MAX  (20),
      .SCAN_DIV    (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (ena && rst_n) ncyc++;
      bus.anim_inc   = 1'b0;
      bus.anim_dec   = 1'b0;
      bus.speed_down = 1'b0;
      bus.speed_up   = 1'b0;
      bus.pause_tgl  = 1'b0;
      bus.dir_tgl    = 1'b0;
   endtask

   task automatic wait_tick(input string tag, input int gap);
      for (int i = 1; i <= gap; i++) begin
         step();
         check_val({tag, "_tick"}, 32'(bus.tick), (i == gap) ? 32'd1 : 32'd0);
      end
   endtask

   function automatic logic [31:0] digit_exp();
      return 32'(1) << ((ncyc / 4) % 4);
   endfunction

   task automatic check_reset(input string tag);
      check_val({tag, "_anim"},   32'(bus.anim), 32'd0);
      check_val({tag, "_frame"},  32'(bus.frame), 32'd0);
      check_val({tag, "_tick"},   32'(bus.tick), 32'd0);
      check_val({tag, "_paused"}, 32'(bus.paused), 32'd0);
      check_val({tag, "_dir"},    32'(bus.dir_rev), 32'd0);
      check_val({tag, "_period"}, 32'(bus.period), 32'd10);
      check_val({tag, "_digit"},  32'(bus.digit_sel), 32'd1);
   endtask

   int exp_dn [6]  = '{12, 14, 16, 18, 20, 20};
   int exp_up [10] = '{18, 16, 14, 12, 10, 8, 6, 4, 2, 2};

   initial begin
      rst_n           = 1'b1;
      ena             = 1'b1;
      bus.anim_inc    = 1'b0;
      bus.anim_dec    = 1'b0;
      bus.speed_down  = 1'b0;
      bus.speed_up    = 1'b0;
      bus.pause_tgl   = 1'b0;
      bus.dir_tgl     = 1'b0;
      bus.frame_limit = 6'd3;
      #1 rst_n = 1'b0;
      #1 check_reset("rst");
      step();
      step();
      rst_n = 1'b1;
      ncyc  = 0;

      // Free run: tick every 10, frames 1,2,3,0, scan every 4
      for (int n = 1; n <= 45; n++) begin
         step();
         check_val("run_tick",  32'(bus.tick), (n % 10 == 0) ? 32'd1 : 32'd0);
         check_val("run_frame", 32'(bus.frame), 32'((n / 10) % 4));
         check_val("run_digit", 32'(bus.digit_sel), digit_exp());
      end

      // Reverse direction from frame 1
      wait_tick("to_f1", 5);
      check_val("f1", 32'(bus.frame), 32'd1);
      bus.dir_tgl = 1'b1;
      wait_tick("rev_a", 10);
      check_val("dir_rev", 32'(bus.dir_rev), 32'd1);
      check_val("rev_f0", 32'(bus.frame), 32'd0);
      wait_tick("rev_b", 10);
      check_val("rev_f3", 32'(bus.frame), 32'd3);
      wait_tick("rev_c", 10);
      check_val("rev_f2", 32'(bus.frame), 32'd2);

      // Pause for 30 clocks, scan keeps going
      bus.pause_tgl = 1'b1;
      step();
      check_val("pause_on", 32'(bus.paused), 32'd1);
      for (int i = 0; i < 30; i++) begin
         step();
         check_val("pause_tick",  32'(bus.tick), 32'd0);
         check_val("pause_frame", 32'(bus.frame), 32'd2);
         check_val("pause_digit", 32'(bus.digit_sel), digit_exp());
      end
      bus.pause_tgl = 1'b1;
      step();
      check_val("pause_off", 32'(bus.paused), 32'd0);
      wait_tick("resume", 8);
      check_val("resume_f1", 32'(bus.frame), 32'd1);

      // Animation wrap both ways
      bus.anim_dec = 1'b1;
      step();
      check_val("dec_anim",  32'(bus.anim), 32'd50);
      check_val("dec_frame", 32'(bus.frame), 32'd0);
      check_val("dec_tick",  32'(bus.tick), 32'd0);
      wait_tick("post_dec", 10);
      check_val("post_dec_f3", 32'(bus.frame), 32'd3);
      bus.anim_inc = 1'b1;
      bus.anim_dec = 1'b1;
      step();
      check_val("incdec_anim",  32'(bus.anim), 32'd0);
      check_val("incdec_frame", 32'(bus.frame), 32'd0);

      // Period saturation
      for (int i = 0; i < 6; i++) begin
         bus.speed_down = 1'b1;
         step();
         check_val("spd_down", 32'(bus.period), 32'(exp_dn[i]));
      end
      for (int i = 0; i < 10; i++) begin
         bus.speed_up = 1'b1;
         step();
         check_val("spd_up", 32'(bus.period), 32'(exp_up[i]));
      end
      for (int i = 0; i < 4; i++) begin
         bus.speed_down = 1'b1;
         step();
      end
      check_val("spd_back", 32'(bus.period), 32'd10);
      bus.anim_inc = 1'b1;
      step();
      check_val("inc_anim",  32'(bus.anim), 32'd1);
      check_val("inc_frame", 32'(bus.frame), 32'd0);
      check_val("inc_tick",  32'(bus.tick), 32'd0);

      // Shrink period past the divider: divider at 7, period 8 -> 6
      for (int i = 0; i < 6; i++) step();
      bus.speed_up = 1'b1;
      step();
      check_val("shr_p8",   32'(bus.period), 32'd8);
      check_val("shr_t8",   32'(bus.tick), 32'd0);
      bus.speed_up = 1'b1;
      step();
      check_val("shr_p6",   32'(bus.period), 32'd6);
      check_val("shr_t6",   32'(bus.tick), 32'd0);
      wait_tick("shrink", 6);
      check_val("shr_f3", 32'(bus.frame), 32'd3);

      // Frame limit drops below current frame
      bus.frame_limit = 6'd1;
      step();
      check_val("guard_frame", 32'(bus.frame), 32'd0);
      check_val("guard_tick",  32'(bus.tick), 32'd0);

      // Enable low: pulses ignored, state frozen
      ena = 1'b0;
      for (int i = 0; i < 20; i++) begin
         bus.anim_inc   = 1'b1;
         bus.anim_dec   = 1'b1;
         bus.speed_down = 1'b1;
         bus.speed_up   = 1'b1;
         bus.pause_tgl  = 1'b1;
         bus.dir_tgl    = 1'b1;
         step();
         check_val("ena_anim",   32'(bus.anim), 32'd1);
         check_val("ena_frame",  32'(bus.frame), 32'd0);
         check_val("ena_period", 32'(bus.period), 32'd6);
         check_val("ena_paused", 32'(bus.paused), 32'd0);
         check_val("ena_dir",    32'(bus.dir_rev), 32'd1);
         check_val("ena_tick",   32'(bus.tick), 32'd0);
         check_val("ena_digit",  32'(bus.digit_sel), digit_exp());
      end

      // Asynchronous reset mid-period
      ena = 1'b1;
      step();
      step();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset("arst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
